// File: rtl/axi_video_scanout_pkg.sv
// rtl/axi_video_scanout_pkg.sv - shared constants and state type for the video scanout block
package axi_video_pkg;

  localparam int FRAME_WIDTH_DEF  = 1920;
  localparam int FRAME_HEIGHT_DEF = 1080;

  localparam logic [2:0] AXSIZE_4B    = 3'h2;
  localparam logic [1:0] AXBURST_INCR = 2'h1;
  localparam logic [3:0] AXCACHE_BUF  = 4'h2;
  localparam logic [1:0] RESP_OKAY    = 2'b00;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } scan_state_t;

endpackage

// File: rtl/axi_video_scanout_if.sv
// rtl/axi_video_scanout_if.sv - AXI4 read channels plus the outgoing pixel stream
interface axi_video_scanout_if;

  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic [3:0]  m_axi_arcache;
  logic [2:0]  m_axi_arprot;
  logic [3:0]  m_axi_arqos;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast;
  logic        m_axi_rvalid;
  logic        m_axi_rready;
  logic [23:0] pix_data_o;
  logic        pix_valid_o;
  logic        pix_ready_i;
  logic        pix_sof_o;
  logic        pix_eol_o;

  modport master (
    output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arcache,
           m_axi_arprot, m_axi_arqos, m_axi_arvalid, m_axi_rready,
           pix_data_o, pix_valid_o, pix_sof_o, pix_eol_o,
    input  m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid, pix_ready_i
  );

  modport slave (
    input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arcache,
           m_axi_arprot, m_axi_arqos, m_axi_arvalid, m_axi_rready,
           pix_data_o, pix_valid_o, pix_sof_o, pix_eol_o,
    output m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid, pix_ready_i
  );

endinterface

// File: rtl/axi_video_scanout_fifo.sv
// rtl/axi_video_scanout_fifo.sv - first-word-fall-through FIFO with occupancy count
module sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 64
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_head,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_pop   = i_pop && !o_empty;
  // a push into a full FIFO is only accepted when the head leaves in the same cycle
  assign w_push  = i_push && (!w_full || w_pop);
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/axi_video_scanout.sv
// rtl/axi_video_scanout.sv - AXI4 read master scanning a linear XRGB frame out as a pixel stream
module axi_video_scanout
  import axi_video_pkg::*;
#(
  parameter int FRAME_WIDTH  = FRAME_WIDTH_DEF,
  parameter int FRAME_HEIGHT = FRAME_HEIGHT_DEF,
  parameter int BURST_LEN    = 16,
  parameter int FIFO_DEPTH   = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] base_addr_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  axi_video_scanout_if.master bus
);

  localparam int TOTAL_BURSTS = (FRAME_WIDTH * FRAME_HEIGHT) / BURST_LEN;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int XW = $clog2(FRAME_WIDTH);
  localparam int YW = $clog2(FRAME_HEIGHT);

  scan_state_t   r_state;
  logic [31:0]   r_araddr;
  logic [31:0]   r_bursts;
  logic          r_arvalid;
  logic          r_busy;
  logic          r_done;
  logic          r_error;
  logic [CW-1:0] r_reserved;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;

  logic [23:0]   w_head;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [CW:0]   w_used;
  logic          w_credit_ok;
  logic          w_ar_hs;
  logic          w_r_hs;
  logic          w_pix_hs;
  logic          w_x_last;
  logic          w_last_pix;
  logic          w_unused;

  assign w_ar_hs     = r_arvalid && bus.m_axi_arready;
  assign w_r_hs      = bus.m_axi_rvalid && r_busy;
  assign w_pix_hs    = !w_empty && bus.pix_ready_i;
  assign w_x_last    = (r_x == XW'(FRAME_WIDTH - 1));
  assign w_last_pix  = w_pix_hs && w_x_last && (r_y == YW'(FRAME_HEIGHT - 1));
  // slots already filled plus slots promised to bursts still in flight
  assign w_used      = {1'b0, w_count} + {1'b0, r_reserved};
  assign w_credit_ok = (w_used <= (CW + 1)'(FIFO_DEPTH - BURST_LEN));
  assign w_unused    = ^{bus.m_axi_rlast, bus.m_axi_rdata[31:24]};

  sync_fifo #(
    .WIDTH (24),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (clk_i),
    .i_rst       (rst_i),
    .i_push      (w_r_hs),
    .i_push_data (bus.m_axi_rdata[23:0]),
    .i_pop       (w_pix_hs),
    .o_head      (w_head),
    .o_empty     (w_empty),
    .o_count     (w_count)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_araddr   <= '0;
      r_bursts   <= '0;
      r_arvalid  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_reserved <= '0;
    end else begin
      r_done     <= 1'b0;
      r_reserved <= r_reserved + (w_ar_hs ? CW'(BURST_LEN) : '0) - (w_r_hs ? CW'(1) : '0);
      if (w_r_hs && bus.m_axi_rresp != RESP_OKAY) r_error <= 1'b1;
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_araddr <= base_addr_i;
            r_bursts <= '0;
            r_error  <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= FETCH;
          end
        end
        FETCH: begin
          // arvalid only rises a cycle after the previous handshake, once the reservation is visible
          if (w_ar_hs) begin
            r_arvalid <= 1'b0;
            r_araddr  <= r_araddr + 32'(BURST_LEN * 4);
            r_bursts  <= r_bursts + 32'd1;
            if (r_bursts == 32'(TOTAL_BURSTS - 1)) r_state <= DRAIN;
          end else if (!r_arvalid && w_credit_ok) begin
            r_arvalid <= 1'b1;
          end
        end
        DRAIN: begin
          if (w_last_pix) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_pix_hs) begin
      if (w_x_last) begin
        r_x <= '0;
        r_y <= (r_y == YW'(FRAME_HEIGHT - 1)) ? '0 : r_y + YW'(1);
      end else begin
        r_x <= r_x + XW'(1);
      end
    end
  end

  assign busy_o            = r_busy;
  assign done_o            = r_done;
  assign error_o           = r_error;
  assign bus.m_axi_araddr  = r_araddr;
  assign bus.m_axi_arlen   = 8'(BURST_LEN - 1);
  assign bus.m_axi_arsize  = AXSIZE_4B;
  assign bus.m_axi_arburst = AXBURST_INCR;
  assign bus.m_axi_arcache = AXCACHE_BUF;
  assign bus.m_axi_arprot  = 3'h0;
  assign bus.m_axi_arqos   = 4'h0;
  assign bus.m_axi_arvalid = r_arvalid;
  assign bus.m_axi_rready  = r_busy;
  assign bus.pix_valid_o   = !w_empty;
  assign bus.pix_data_o    = w_empty ? 24'h0 : w_head;
  assign bus.pix_sof_o     = !w_empty && (r_x == '0) && (r_y == '0);
  assign bus.pix_eol_o     = !w_empty && w_x_last;

endmodule

// File: tb/tb_axi_video_scanout.sv
// tb/tb_axi_video_scanout.sv - randomized bench for axi_video_scanout against a frame-level model
module tb_axi_video_scanout;

  localparam int W     = 8;
  localparam int H     = 4;
  localparam int BL    = 4;
  localparam int DEPTH = 16;
  localparam int TOT   = W * H;
  localparam int NBUR  = TOT / BL;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic        busy;
  logic        done;
  logic        err;

  axi_video_scanout_if bus ();

  axi_video_scanout #(
    .FRAME_WIDTH  (W),
    .FRAME_HEIGHT (H),
    .BURST_LEN    (BL),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .base_addr_i (base_addr),
    .busy_o      (busy),
    .done_o      (done),
    .error_o     (err),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // memory image: low 24 bits are the word index within the frame xor a per-frame seed
  logic [31:0] mem_base;
  logic [23:0] mem_seed;
  logic [31:0] err_addr;
  int          ar_pct, r_pct, pix_pct;
  bit          pix_hold;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] idx;
    idx = (a - mem_base) >> 2;
    return {a[9:2] ^ 8'hC3, idx[23:0] ^ mem_seed};
  endfunction

  logic [31:0] exp_base;
  int          pix_idx, ar_cnt, beat_cnt, done_cnt, sof_cnt, eol_cnt;
  bit          in_frame, exp_err, exp_done;
  bit          prev_arv, prev_arr;
  logic [31:0] prev_addr;
  bit          s_ar_hs, s_r_hs;
  logic [31:0] s_ar_addr;
  logic [23:0] pix_log [TOT];
  logic [31:0] ar_log [NBUR];

  function automatic logic [23:0] exp_pix(input int k);
    logic [31:0] w;
    w = mem_word(exp_base + 32'(4 * k));
    return w[23:0];
  endfunction

  // compare process: frame-level model of addresses, pixel order, flags, credits and status
  initial begin
    done_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_ctrl", 32'({busy, done, err}), 32'h0);
        chk("rst_axi", 32'({bus.m_axi_arvalid, bus.m_axi_rready}), 32'h0);
        chk("rst_araddr", bus.m_axi_araddr, 32'h0);
        chk("rst_pix", 32'({bus.pix_valid_o, bus.pix_sof_o, bus.pix_eol_o}), 32'h0);
        chk("rst_pix_data", 32'(bus.pix_data_o), 32'h0);
        in_frame = 0; exp_err = 0; exp_done = 0;
        pix_idx = 0; ar_cnt = 0; beat_cnt = 0;
        prev_arv = 0; prev_arr = 0; s_ar_hs = 0; s_r_hs = 0;
      end else begin
        chk("busy", 32'(busy), 32'(in_frame));
        chk("done", 32'(done), 32'(exp_done));
        chk("error", 32'(err), 32'(exp_err));
        chk("rready", 32'(bus.m_axi_rready), 32'(in_frame));
        if (done) begin
          done_cnt++;
          chk("done_pixels", pix_idx, TOT);
          chk("done_ars", ar_cnt, NBUR);
        end
        exp_done = 0;
        if (start && !busy) begin
          exp_base = base_addr; in_frame = 1; exp_err = 0;
          pix_idx = 0; ar_cnt = 0; beat_cnt = 0; sof_cnt = 0; eol_cnt = 0;
        end
        if (prev_arv && !prev_arr) begin
          chk("ar_hold_valid", 32'(bus.m_axi_arvalid), 32'h1);
          chk("ar_hold_addr", bus.m_axi_araddr, prev_addr);
        end
        if (bus.m_axi_arvalid) begin
          chk("ar_credit", 32'(DEPTH - (ar_cnt * BL - pix_idx) >= BL), 32'h1);
          chk("ar_in_range", 32'(ar_cnt < NBUR), 32'h1);
          chk("araddr", bus.m_axi_araddr, exp_base + 32'(ar_cnt * BL * 4));
          if (bus.m_axi_arready) begin
            chk("ar_attr", 32'({bus.m_axi_arlen, bus.m_axi_arsize, bus.m_axi_arburst,
                                bus.m_axi_arcache, bus.m_axi_arprot, bus.m_axi_arqos}),
                32'({8'(BL - 1), 3'h2, 2'h1, 4'h2, 3'h0, 4'h0}));
            ar_log[ar_cnt % NBUR] = bus.m_axi_araddr;
            ar_cnt++;
          end
        end
        prev_arv  = bus.m_axi_arvalid;
        prev_arr  = bus.m_axi_arready;
        prev_addr = bus.m_axi_araddr;
        s_ar_hs   = bus.m_axi_arvalid && bus.m_axi_arready;
        s_ar_addr = bus.m_axi_araddr;
        if (bus.pix_valid_o) begin
          chk("pix_available", 32'(in_frame && pix_idx < beat_cnt), 32'h1);
          if (pix_idx < TOT) begin
            chk("pix_data", 32'(bus.pix_data_o), 32'(exp_pix(pix_idx)));
            chk("pix_sof", 32'(bus.pix_sof_o), 32'(pix_idx == 0));
            chk("pix_eol", 32'(bus.pix_eol_o), 32'(pix_idx % W == W - 1));
            if (bus.pix_ready_i) begin
              pix_log[pix_idx] = bus.pix_data_o;
              sof_cnt += int'(bus.pix_sof_o);
              eol_cnt += int'(bus.pix_eol_o);
              pix_idx++;
              if (pix_idx == TOT) begin in_frame = 0; exp_done = 1; end
            end
          end
        end else begin
          chk("pix_idle_flags", 32'({bus.pix_sof_o, bus.pix_eol_o}), 32'h0);
        end
        s_r_hs = bus.m_axi_rvalid && bus.m_axi_rready;
        if (s_r_hs) begin
          beat_cnt++;
          if (bus.m_axi_rresp != 2'b00) exp_err = 1;
        end
        chk("fifo_bound", 32'(beat_cnt - pix_idx <= DEPTH), 32'h1);
      end
    end
  end

  // AXI slave memory and pixel sink with random stalls
  logic [31:0] ar_q [$];
  int          beat;
  initial begin
    logic [31:0] a;
    beat = 0;
    bus.m_axi_arready = 1'b0; bus.m_axi_rvalid = 1'b0; bus.m_axi_rdata = '0;
    bus.m_axi_rresp = 2'b00; bus.m_axi_rlast = 1'b0; bus.pix_ready_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        ar_q.delete(); beat = 0;
        bus.m_axi_arready = 1'b0; bus.m_axi_rvalid = 1'b0; bus.m_axi_rlast = 1'b0;
      end else begin
        if (s_ar_hs) ar_q.push_back(s_ar_addr);
        if (s_r_hs) begin
          if (beat == BL - 1) begin beat = 0; void'(ar_q.pop_front()); end
          else beat++;
        end
        bus.m_axi_arready = 1'($urandom_range(99) < ar_pct);
        if (!bus.m_axi_rvalid || s_r_hs) begin
          bus.m_axi_rvalid = (ar_q.size() > 0) && ($urandom_range(99) < r_pct);
          if (ar_q.size() > 0) begin
            a = ar_q[0] + 32'(4 * beat);
            bus.m_axi_rdata = mem_word(a);
            bus.m_axi_rresp = (a == err_addr) ? 2'b10 : 2'b00;
            bus.m_axi_rlast = 1'(beat == BL - 1);
          end
        end
      end
      bus.pix_ready_i = !pix_hold && ($urandom_range(99) < pix_pct);
    end
  end

  task automatic start_frame(input logic [31:0] b, input logic [23:0] s,
                             input logic [31:0] ea, output int d0);
    mem_base = b; mem_seed = s; err_addr = ea; d0 = done_cnt;
    @(posedge clk); #1; start = 1'b1; base_addr = b;
    @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int limit);
    int n = 0;
    while (done_cnt == d0 && n < limit) begin @(negedge clk); #1; n++; end
    chk("done_pulse", done_cnt, d0 + 1);
    repeat (4) @(negedge clk);
    #1;
    chk("done_once", done_cnt, d0 + 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, pixels=%0d", pix_idx);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, n, p, fill;
    logic [31:0] b;
    rst = 1'b1; start = 1'b0; base_addr = '0; pix_hold = 0;
    ar_pct = 100; r_pct = 100; pix_pct = 100;
    mem_base = '0; mem_seed = '0; err_addr = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // clean frame, memory word[i] = i
    start_frame(32'h1000_0000, 24'h0, 32'hFFFF_FFFF, d0);
    wait_done(d0, 400);
    chk("t1_ar_count", ar_cnt, 8);
    chk("t1_ar_first", ar_log[0], 32'h1000_0000);
    chk("t1_ar_last", ar_log[7], 32'h1000_0070);
    chk("t1_pix0", 32'(pix_log[0]), 32'd0);
    chk("t1_pix13", 32'(pix_log[13]), 32'd13);
    chk("t1_pix31", 32'(pix_log[31]), 32'd31);
    chk("t1_sof_count", sof_cnt, 1);
    chk("t1_eol_count", eol_cnt, 4);
    chk("t1_error", 32'(err), 32'h0);

    // bad response on beat 5
    start_frame(32'h2000_0000, 24'h00A5C3, 32'h2000_0014, d0);
    wait_done(d0, 400);
    chk("t4_error_set", 32'(err), 32'h1);
    chk("t4_all_pixels", pix_idx, TOT);
    repeat (5) @(negedge clk);
    #1 chk("t4_error_sticky", 32'(err), 32'h1);

    // start pulsed while busy is ignored
    ar_pct = 50; r_pct = 50; pix_pct = 50;
    start_frame(32'h3000_0000, 24'h123456, 32'hFFFF_FFFF, d0);
    #1 chk("t5_error_cleared", 32'(err), 32'h0);
    repeat (10) @(posedge clk);
    #1 start = 1'b1; base_addr = 32'h4000_0000;
    @(posedge clk); #1 start = 1'b0;
    wait_done(d0, 1000);
    chk("t5_ar_count", ar_cnt, NBUR);

    // pixel sink stalled for 200 cycles mid-frame
    ar_pct = 100; r_pct = 100; pix_pct = 100;
    start_frame(32'h5000_0000, 24'h0F0F0F, 32'hFFFF_FFFF, d0);
    n = 0;
    while (pix_idx < 8 && n < 500) begin @(negedge clk); #1; n++; end
    chk("t2_reach_mid", 32'(pix_idx >= 8), 32'h1);
    pix_hold = 1;
    repeat (200) @(negedge clk);
    #1;
    p = pix_idx;
    fill = (BL * ((p + DEPTH) / BL) < TOT) ? BL * ((p + DEPTH) / BL) - p : TOT - p;
    chk("t2_fifo_fill", beat_cnt - p, fill);
    chk("t2_arvalid_low", 32'(bus.m_axi_arvalid), 32'h0);
    chk("t2_pix_valid", 32'(bus.pix_valid_o), 32'h1);
    pix_hold = 0;
    wait_done(d0, 400);

    // random stalls over several frames
    ar_pct = 50; r_pct = 50; pix_pct = 50;
    for (int f = 0; f < 8; f++) begin
      b = $urandom() & 32'h7FFF_FFF0;
      start_frame(b, 24'($urandom()), 32'hFFFF_FFFF, d0);
      wait_done(d0, 2000);
    end

    // reset mid-fetch, then a clean frame
    start_frame(32'h6000_0000, 24'h777777, 32'hFFFF_FFFF, d0);
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    chk("t6_no_done", done_cnt, d0);
    start_frame(32'h7000_0000, 24'h0000FF, 32'hFFFF_FFFF, d0);
    wait_done(d0, 2000);
    chk("t6_sof_count", sof_cnt, 1);
    chk("t6_eol_count", eol_cnt, H);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
